// File: rtl/sram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_rw_arbiter
// Description : Round-robin arbiter and sequencer that shares the single RW
//               port of a 1-cycle-latency SRAM macro between two requesters.
//               Writes are posted (byte-masked). Reads are tracked in flight
//               and returned through a one-entry valid/ready buffer per port.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rw_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    localparam int MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset_n,

    // Port 0
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [MASK_W-1:0] p0_req_wmask,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    input  logic              p0_resp_ready,
    output logic [DATA_W-1:0] p0_resp_data,

    // Port 1
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [MASK_W-1:0] p1_req_wmask,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [DATA_W-1:0] p1_resp_data,

    // SRAM macro RW port
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int NUM_PORTS = 2;

    // ------------------------------------------------------------------
    // Per-port views of the request/response ports, so the rest of the
    // logic can be written once and indexed by port number.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_req_valid;
    logic [NUM_PORTS-1:0] w_req_write;
    logic [NUM_PORTS-1:0] w_resp_ready;
    logic [ADDR_W-1:0]    w_req_addr  [NUM_PORTS];
    logic [MASK_W-1:0]    w_req_wmask [NUM_PORTS];
    logic [DATA_W-1:0]    w_req_wdata [NUM_PORTS];

    assign w_req_valid    = {p1_req_valid,  p0_req_valid};
    assign w_req_write    = {p1_req_write,  p0_req_write};
    assign w_resp_ready   = {p1_resp_ready, p0_resp_ready};
    assign w_req_addr[0]  = p0_req_addr;
    assign w_req_addr[1]  = p1_req_addr;
    assign w_req_wmask[0] = p0_req_wmask;
    assign w_req_wmask[1] = p1_req_wmask;
    assign w_req_wdata[0] = p0_req_wdata;
    assign w_req_wdata[1] = p1_req_wdata;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 r_last_grant;            // port granted most recently
    logic [NUM_PORTS-1:0] r_inflight;              // read issued last cycle
    logic [NUM_PORTS-1:0] r_resp_valid;            // response buffer occupied
    logic [DATA_W-1:0]    r_resp_data [NUM_PORTS]; // response buffer payload

    // ------------------------------------------------------------------
    // Eligibility. A read may only issue when nothing is in flight for
    // the port and its response buffer is free (or draining this cycle),
    // which caps each port at one outstanding read. Writes need no
    // response slot and are always eligible when valid.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_read_ok;
    logic [NUM_PORTS-1:0] w_elig;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_elig
        assign w_read_ok[p] = !r_inflight[p] &&
                              (!r_resp_valid[p] || w_resp_ready[p]);
        assign w_elig[p]    = w_req_valid[p] && (w_req_write[p] || w_read_ok[p]);
    end

    // ------------------------------------------------------------------
    // Round-robin grant; on contention the port not granted last wins.
    // Grants are suppressed while reset is asserted so the macro sees no
    // enables during reset.
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_sel;

    // Select one eligible port, alternating under contention.
    always_comb begin
        w_grant = '0;
        if (reset_n) begin
            case (w_elig)
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_sel        = w_grant[1];
    assign p0_req_ready = w_grant[0];
    assign p1_req_ready = w_grant[1];

    // Drive the macro from the granted port; everything is zero when idle
    // and the byte mask is zero on reads.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (|w_grant) begin
            sram_en    = 1'b1;
            sram_wmode = w_req_write[w_sel];
            sram_addr  = w_req_addr[w_sel];
            sram_wmask = w_req_write[w_sel] ? w_req_wmask[w_sel] : '0;
            sram_wdata = w_req_wdata[w_sel];
        end
    end

    // Remember which port was granted last; reset favours port 0 first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_sel;
        end
    end

    // A granted read is in flight for exactly the following cycle, while
    // the macro presents its data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= w_grant & ~w_req_write;
        end
    end

    // Capture returning read data into the per-port buffer. A capture on
    // the same edge as a consume keeps the buffer valid with new data;
    // otherwise the payload is frozen until consumed, so later writes to
    // the same address cannot disturb a buffered response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_resp_data[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (r_inflight[p]) begin
                    r_resp_valid[p] <= 1'b1;
                    r_resp_data[p]  <= sram_rdata;
                end else if (r_resp_valid[p] && w_resp_ready[p]) begin
                    r_resp_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign p0_resp_valid = r_resp_valid[0];
    assign p1_resp_valid = r_resp_valid[1];
    assign p0_resp_data  = r_resp_data[0];
    assign p1_resp_data  = r_resp_data[1];

endmodule
`default_nettype wire

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Two-requester arbiter and sequencer for a single-port read/write SRAM macro with byte-masked writes and 1-cycle registered-address read latency. Examples of such macros are the 512×64 data array and the 64-entry tag arrays. It time-multiplexes the macro's only RW port between two clients using round-robin arbitration. It tracks in-flight reads and returns read data through per-port buffered valid/ready response channels.

## Interface
- ADDR_W, 9, SRAM word address width
- DATA_W, 64, SRAM word width; must be a multiple of 8
- MASK_W, DATA_W/8, byte-enable width (derived, not overridable)

Clock and reset:
- clock  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset

Request and response ports, for p in {0,1}:
- p<p>_req_valid  in  1  request present
- p<p>_req_ready  out  1  request accepted this cycle (granted)
- p<p>_req_write  in  1  1 = masked write, 0 = read
- p<p>_req_addr  in  ADDR_W  word address
- p<p>_req_wmask  in  MASK_W  byte enables (writes only)
- p<p>_req_wdata  in  DATA_W  write data
- p<p>_resp_valid  out  1  read data available
- p<p>_resp_ready  in  1  requester consumes response
- p<p>_resp_data  out  DATA_W  read data, stable while resp_valid

SRAM side:
- sram_addr  out  ADDR_W  to macro RW0_addr
- sram_en  out  1  to RW0_en
- sram_wmode  out  1  to RW0_wmode
- sram_wmask  out  MASK_W  to RW0_wmask
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata; valid the cycle after a read enable

## Operation
- State: last_grant (1b), inflight_p (1b/port), resp_valid_p (1b/port), resp_data_p (DATA_W/port).
- Read eligibility per port: read_ok_p = !inflight_p && (!resp_valid_p || p<p>_resp_ready). This allows at most one read outstanding per port.
- Request eligibility per port: elig_p = req_valid_p && (req_write_p || read_ok_p).
- Arbitration:
  - Both eligible: grant the port != last_grant.
  - One eligible: grant that port.
  - None eligible: no grant.
  - last_grant updates on every grant.
  - An ineligible port never blocks the other.
- req_ready_p = grant_p. Ready may depend on valid; valid must not depend on ready.
- On grant, the SRAM outputs are driven combinationally from the granted port in the same cycle:
  - sram_en = 1
  - sram_wmode = req_write
  - addr, wmask, wdata from the granted port
  - sram_wmask is forced to 0 on reads.
- With no grant, sram_en=0 and all other SRAM outputs are driven to 0.
- A granted write is posted. It produces no response and commits at the end of the grant cycle.
- A granted read sets inflight_p. In the following cycle:
  - sram_rdata is captured into resp_data_p.
  - resp_valid_p is set.
  - inflight_p is cleared.
- resp_valid_p clears on resp_valid_p && resp_ready_p, unless a capture for the same port occurs on the same edge. In that case capture wins and valid stays 1.
- resp_data_p is held unchanged while resp_valid_p=1 and not consumed. Later SRAM writes to the same address do not alter a buffered response.

## Timing
- Reset values (asynchronous on reset_n low):
  - last_grant=1, so port 0 wins the first contention.
  - inflight_p=0, resp_valid_p=0, resp_data_p=0.
  - All SRAM outputs 0; req_ready_p=0 when req_valid_p=0.
- Read latency: request granted in cycle N; resp_valid in cycle N+1 is 0; resp_valid=1 from cycle N+2.
- Per-port read throughput with resp_ready held high: one read every 2 cycles, since read_ok is low during the inflight cycle.
- Write latency: 1 cycle. A read granted in cycle N+1 to the same address returns the merged write data.
- Aggregate throughput: one SRAM access per cycle. Under sustained contention the two ports alternate strictly.
- Reset asserted mid-operation: in-flight reads and buffered responses are discarded, and no response appears after reset release. A write granted in the cycle reset asserts is not guaranteed to commit.

## Test plan
- Reset: hold reset_n=0 with random inputs -> sram_en=0, p0/p1_resp_valid=0, all SRAM outputs 0. Release, then assert p0 and p1 reads in the same cycle -> p0 granted first.
- Read latency: after reset, p0 writes addr 0x1A5 data 0x0123456789ABCDEF with mask 0xFF. The next cycle, p0 reads 0x1A5 -> p0_resp_valid rises exactly 2 cycles after the grant with data 0x0123456789ABCDEF.
- Byte merge: write 0xFFFF…FF with mask 0xFF, then write 0x0 with mask 0x0F, then read the same address -> 0xFFFFFFFF00000000.
- Round-robin: both ports issue back-to-back writes for 8 cycles -> grants alternate p0,p1,p0,… and sram_en=1 every cycle.
- Backpressure:
  - p1 reads addr 3 and holds p1_resp_ready=0 -> response data held constant.
  - A further p1 read is not granted, while a p1 write is granted.
  - A p0 write to addr 3 does not change p1_resp_data.
  - Raising ready consumes the response, and the pending read is granted in the same cycle.
- Reset mid-flight: assert reset_n=0 the cycle after a read grant -> no response after release, and inflight state is cleared (a new read is granted immediately).
